serial_add_arb: RTL and testbench
=================================

Name: serial_add_arb

Overview:
- Scheduler for one shared bit-serial full-add cell: two carry-chained half-adder stages plus a carry flop, sequenced over WIDTH cycles.
- Two requesters submit operand pairs through valid/ready. A round-robin arbiter grants one request at a time and serialises the add LSB-first.
- The result returns on a single valid/ready port, tagged with the requester id.
- Sits between operand producers and the accumulate datapath, where area matters more than latency.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.
- CW, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  WIDTH  requester 0 operand a
- req0_b  in  WIDTH  requester 0 operand b
- req1_valid  in  1  requester 1 has operands
- req1_ready  out  1  requester 1 accepted this cycle
- req1_a  in  WIDTH  requester 1 operand a
- req1_b  in  WIDTH  requester 1 operand b
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_sum  out  WIDTH  (a+b) mod 2^WIDTH
- res_cout  out  1  carry out of bit WIDTH-1
- res_id  out  1  requester that issued the result
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE; rr pointer = 0 (requester 0 favoured).
  - res_valid, res_sum, res_cout, res_id = 0; busy = 0.
  - Internal shift registers, carry flop and counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - reqN_ready is combinational and goes to at most one requester.
  - Only one valid: that requester gets ready.
  - Both valid: the requester selected by rr gets ready.
  - Neither valid: both readys are 0.
  - On valid&ready: latch a, b and the id; clear carry and counter; toggle rr to the non-granted requester; go to RUN.
  - A valid that drops before its handshake is legal and causes no state change.
- RUN (one bit per clock, WIDTH cycles):
  - p = a[0]^b[0]; g = a[0]&b[0]; s = p^c; c_next = g | (p&c).
  - Shift a and b right by 1. Shift s into the sum register at the MSB.
  - counter+1 each cycle.
  - When the counter reaches WIDTH-1, that same edge stores the final bit and c_next, then moves to DONE.
- DONE:
  - res_valid = 1 (registered).
  - res_sum, res_cout and res_id are held stable until res_valid&res_ready.
  - On handshake: res_valid = 0 and return to IDLE.
- Readys are 0 in RUN and DONE. Requests arriving there wait; their operands are not sampled.
- Latency: request handshake at edge T. res_valid rises after edge T+WIDTH, so it is first visible in the cycle following T+WIDTH.
- Throughput: a new grant is possible at the earliest one cycle after the result handshake. Minimum spacing is WIDTH+2 cycles per operation.
- No pipelining: at most one operation is in flight.
- Wrap-around: the sum wraps mod 2^WIDTH and overflow is reported only on res_cout. The counter wraps to 0 on the RUN->DONE transition.
- Reset mid-RUN or mid-DONE aborts the operation with no result emitted. rr returns to 0.
- Fairness: with both requesters continuously valid, grants alternate strictly.

Test Plan:
- WIDTH=8; req0 a=0x0F, b=0x01 handshake at edge T -> res_valid in the cycle after T+8, res_sum=0x10, res_cout=0, res_id=0.
- req1 a=0xFF, b=0x01 -> res_sum=0x00, res_cout=1, res_id=1; busy=1 from T+1 until the result handshake.
- Both valid on the first cycle after reset: req0 0x12+0x34, req1 0xA0+0x70 -> first result 0x46/cout 0/id 0; second result 0x10/cout 1/id 1. req1_ready stays 0 until the first result handshakes.
- res_ready held 0 for 5 cycles in DONE -> res_valid, res_sum and res_id stay stable; both readys stay 0. One cycle after res_ready=1, IDLE grants the pending request.
- rst_n pulsed low during RUN at bit 4 -> res_valid=0 and busy=0 immediately. After release with req1 valid, req1 is granted, and the next contended grant goes to req0.
- Both requesters valid continuously for 4 operations -> res_id sequence is 0, 1, 0, 1, and each result equals (a+b) mod 256 with the correct cout.

Source files
------------

// File: rtl/serial_add_arb.sv
// Round-robin scheduler for one shared bit-serial full-add cell.
// Two requesters, LSB-first add over WIDTH cycles, result tagged with requester id.
module serial_add_arb #(
  parameter  int WIDTH = 8,
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nx;
  logic             rr, id, c;
  logic             gnt0, gnt1, last;
  logic             p, g, s, c_nx;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic [CW-1:0]    cnt;

  // rr names the requester that wins when both are valid
  assign gnt0 = (state == IDLE) & req0_valid & (~req1_valid | ~rr);
  assign gnt1 = (state == IDLE) & req1_valid & (~req0_valid |  rr);
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // two carry-chained half adders
  assign p    = a_sr[0] ^ b_sr[0];
  assign g    = a_sr[0] & b_sr[0];
  assign s    = p ^ c;
  assign c_nx = g | (p & c);
  assign last = (cnt == CW'(WIDTH - 1));

  assign res_sum  = s_sr;
  assign res_cout = c;
  assign res_id   = id;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt0 | gnt1) state_nx = RUN;
      RUN:     if (last)        state_nx = DONE;
      DONE:    if (res_ready)   state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      s_sr      <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      id        <= 1'b0;
      rr        <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt0 | gnt1) begin
          a_sr <= gnt0 ? req0_a : req1_a;
          b_sr <= gnt0 ? req0_b : req1_b;
          id   <= gnt1;
          rr   <= gnt0;
          c    <= 1'b0;
          cnt  <= '0;
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          s_sr <= {s, s_sr[WIDTH-1:1]};
          c    <= c_nx;
          cnt  <= last ? '0 : cnt + CW'(1);
          if (last) res_valid <= 1'b1;
        end
        DONE: if (res_ready) res_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_arb.sv
// Randomized bench for serial_add_arb against a cycle-count reference model.
module tb_serial_add_arb;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             req0_ready, req1_ready, res_valid, res_cout, res_id, busy;
  logic [WIDTH-1:0] res_sum;

  serial_add_arb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: an op is in flight for WIDTH cycles, then waits for the consumer
  bit       m_busy = 0, m_rr = 0, m_id = 0;
  int       m_age = 0;
  bit [8:0] m_res = '0;
  bit       g0, g1;
  int       got_id[$];
  bit [7:0] got_sum[$];
  bit       got_cout[$];

  task automatic cyc(input bit v0, input bit [7:0] a0, input bit [7:0] b0,
                     input bit v1, input bit [7:0] a1, input bit [7:0] b1, input bit rdy);
    bit ev;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    res_ready  = rdy;
    #1;
    g0 = !m_busy && v0 && (!v1 || !m_rr);
    g1 = !m_busy && v1 && (!v0 ||  m_rr);
    ev = m_busy && (m_age >= WIDTH);
    chk("ready0", req0_ready, g0);
    chk("ready1", req1_ready, g1);
    chk("res_valid", res_valid, ev);
    chk("busy", busy, m_busy);
    if (ev) begin
      chk("res_sum", res_sum, m_res[7:0]);
      chk("res_cout", res_cout, m_res[8]);
      chk("res_id", res_id, m_id);
      if (rdy) begin
        got_id.push_back(int'(res_id));
        got_sum.push_back(res_sum);
        got_cout.push_back(res_cout);
      end
    end
    if (g0 || g1) begin
      m_busy = 1; m_age = 0;
      m_id   = g1;
      m_res  = g0 ? ({1'b0, a0} + {1'b0, b0}) : ({1'b0, a1} + {1'b0, b1});
      m_rr   = g0;
    end else if (m_busy) begin
      if (ev && rdy) m_busy = 0;
      else if (m_age < WIDTH) m_age++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    req0_valid = 0; req1_valid = 0; res_ready = 0;
    rst_n = 0;
    #1;
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", res_sum, 0);
    chk("rst_cout", res_cout, 0);
    chk("rst_id", res_id, 0);
    m_busy = 0; m_rr = 0; m_age = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drain();
    int start = got_id.size();
    int k = 0;
    while (got_id.size() == start && k < 40) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      k++;
    end
    if (k >= 40) chk("drain_timeout", 1, 0);
  endtask

  task automatic pair(input bit [7:0] a0, input bit [7:0] b0, input bit [7:0] a1, input bit [7:0] b1);
    bit p0 = 1, p1 = 1;
    int start = got_id.size();
    int k = 0;
    while (got_id.size() - start < 2 && k < 100) begin
      cyc(p0, a0, b0, p1, a1, b1, 1);
      if (g0) p0 = 0;
      if (g1) p1 = 0;
      k++;
    end
    if (k >= 100) chk("pair_timeout", 1, 0);
  endtask

  initial begin
    int k, base;
    do_reset();

    // single requests, including wrap-around
    cyc(1, 8'h0F, 8'h01, 0, 0, 0, 1);
    drain();
    chk("t1_sum", got_sum[$], 8'h10);
    chk("t1_cout", got_cout[$], 0);
    chk("t1_id", got_id[$], 0);
    cyc(0, 0, 0, 1, 8'hFF, 8'h01, 1);
    drain();
    chk("t2_sum", got_sum[$], 8'h00);
    chk("t2_cout", got_cout[$], 1);
    chk("t2_id", got_id[$], 1);

    // contention right after reset
    do_reset();
    base = got_id.size();
    pair(8'h12, 8'h34, 8'hA0, 8'h70);
    chk("t3_sum0", got_sum[base], 8'h46);
    chk("t3_cout0", got_cout[base], 0);
    chk("t3_id0", got_id[base], 0);
    chk("t3_sum1", got_sum[base+1], 8'h10);
    chk("t3_cout1", got_cout[base+1], 1);
    chk("t3_id1", got_id[base+1], 1);

    // consumer stalls in DONE while req1 waits
    cyc(1, 8'h55, 8'h22, 0, 0, 0, 0);
    k = 0;
    while (!(m_busy && m_age >= WIDTH) && k < 40) begin
      cyc(0, 0, 0, 1, 8'h03, 8'h04, 0);
      k++;
    end
    repeat (5) cyc(0, 0, 0, 1, 8'h03, 8'h04, 0);
    cyc(0, 0, 0, 1, 8'h03, 8'h04, 1);
    chk("t4_sum", got_sum[$], 8'h77);
    cyc(0, 0, 0, 1, 8'h03, 8'h04, 1);
    chk("t4_grant1", req1_ready, 1);
    drain();
    chk("t4_sum1", got_sum[$], 8'h07);

    // reset in the middle of RUN
    cyc(1, 8'hC3, 8'h5A, 0, 0, 0, 1);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 1);
    do_reset();
    base = got_id.size();
    cyc(0, 0, 0, 1, 8'h21, 8'h12, 1);
    chk("t5_grant1", req1_ready, 1);
    drain();
    chk("t5_id_a", got_id[base], 1);
    base = got_id.size();
    pair(8'h01, 8'h02, 8'h03, 8'h04);
    chk("t5_id_b", got_id[base], 0);

    // fairness with both continuously valid
    do_reset();
    base = got_id.size();
    k = 0;
    while (got_id.size() - base < 4 && k < 200) begin
      cyc(1, 8'($urandom), 8'($urandom), 1, 8'($urandom), 8'($urandom), 1);
      k++;
    end
    if (k >= 200) chk("fair_timeout", 1, 0);
    else for (int i = 0; i < 4; i++) chk("fair_id", got_id[base+i], i % 2);

    // random traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(99) < 60), 8'($urandom), 8'($urandom),
          ($urandom_range(99) < 60), 8'($urandom), 8'($urandom),
          ($urandom_range(99) < 70));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
